// File: rtl/serial_adder_pkg.sv
// Shared constants and state type for the bit-serial adder.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow output.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_fa_slice.sv
// Combinational 1-bit full adder, the single arithmetic slice
// reused every cycle by the serial adder.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa_slice plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered Ovf output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fs;
    logic             fco;
    logic             load;
    logic             step;
    logic             last;

    fa_slice u_fa (
        .a  (sha[0]),
        .b  (shb[0]),
        .ci (carry),
        .s  (fs),
        .co (fco)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
    assign res_nx = {fs, res[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            (state == S_RUN): begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = S_DONE;
                end
            end
            (state == S_DONE): begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sha   <= '0;
            shb   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (load) begin
                sha   <= A;
                shb   <= B;
                carry <= Cin;
                cnt   <= '0;
            end
            if (step) begin
                sha   <= sha >> 1;
                shb   <= shb >> 1;
                res   <= res_nx;
                carry <= fco;
                cnt   <= cnt + CNT_W'(1);
            end
            if (last) begin
                S    <= res_nx;
                Cout <= fco;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB slice here
                Ovf  <= carry ^ fco;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an
// arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_sum(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic ci);
        logic [W:0] r;
        r = model_sum(a, b, ci);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op from IDLE and stop on the done cycle (no checks here).
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, output int lat,
                            output int bcnt, output int hold_bad);
        logic [W-1:0] s0;
        logic         c0;
        lat = -1;
        bcnt = 0;
        hold_bad = 0;
        start = 1'b1;
        A = a;
        B = b;
        Cin = ci;
        tick();
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Cin = 1'($urandom);
        s0 = S;
        c0 = Cout;
        for (int n = 0; n < 4 * W; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            if (S !== s0 || Cout !== c0) hold_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, Cout, S} !== '0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b Cout=%b S=%h want all 0",
                     busy, done, Cout, S);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h80};
        logic [W-1:0] tb [5] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h80};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   exp;
        int lat, bc, hb;
        for (int i = 0; i < 5; i++) begin
            drive_op(ta[i], tb[i], tc[i], lat, bc, hb);
            exp = model_sum(ta[i], tb[i], tc[i]);
            n_cmp++;
            if (lat !== W || bc !== W || hb !== 0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d timing: lat=%0d busy_cycles=%0d hold=%0d busy=%b want %0d/%0d/0/0",
                         i, lat, bc, hb, busy, W, W);
            end
            n_cmp++;
            if ({Cout, S} !== exp) begin
                n_bad++;
                $display("FAIL dir%0d sum: got %b_%h want %b_%h",
                         i, Cout, S, exp[W], exp[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_cmp++;
            if (ovf !== model_ovf(ta[i], tb[i], tc[i])) begin
                n_bad++;
                $display("FAIL dir%0d ovf: got %b want %b",
                         i, ovf, model_ovf(ta[i], tb[i], tc[i]));
            end
`endif
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || {Cout, S} !== exp) begin
                n_bad++;
                $display("FAIL dir%0d post: done=%b busy=%b S=%h want 0 0 %h",
                         i, done, busy, S, exp[W-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         ci;
        logic [W:0]   exp;
        int lat, bc, hb;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            ci = 1'($urandom);
            drive_op(a, b, ci, lat, bc, hb);
            exp = model_sum(a, b, ci);
            n_cmp++;
            if (lat !== W || bc !== W || hb !== 0 || {Cout, S} !== exp) begin
                n_bad++;
                $display("FAIL rnd%0d %h+%h+%b: got %b_%h lat=%0d bc=%0d hold=%0d want %b_%h",
                         i, a, b, ci, Cout, S, lat, bc, hb, exp[W], exp[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_cmp++;
            if (ovf !== model_ovf(a, b, ci)) begin
                n_bad++;
                $display("FAIL rnd%0d ovf: got %b want %b",
                         i, ovf, model_ovf(a, b, ci));
            end
`endif
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        start = 1'b1;
        A = 8'h03;
        B = 8'h04;
        Cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        Cin = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 2 * W; n++) begin
            if (done) begin
                pulses++;
                n_cmp++;
                if (S !== 8'h07 || Cout !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ignore_start: got %b_%h want 0_07", Cout, S);
                end
            end
            tick();
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL ignore_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        logic [W:0] exp;
        int lat, bc, hb;
        start = 1'b1;
        A = 8'h10;
        B = 8'h20;
        Cin = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({busy, done, Cout, S} !== '0) begin
            n_bad++;
            $display("FAIL abort: busy=%b done=%b Cout=%b S=%h want all 0",
                     busy, done, Cout, S);
        end
        for (int n = 0; n < 2 * W; n++) begin
            if (done || busy) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL abort_quiet: active cycles %0d want 0", pulses);
        end
        drive_op(8'h10, 8'h20, 1'b0, lat, bc, hb);
        exp = model_sum(8'h10, 8'h20, 1'b0);
        n_cmp++;
        if (lat !== W || {Cout, S} !== exp) begin
            n_bad++;
            $display("FAIL abort_after: got %b_%h lat=%0d want %b_%h lat=%0d",
                     Cout, S, lat, exp[W], exp[W-1:0], W);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa [$];
        logic [W-1:0] qb [$];
        logic         qc [$];
        logic [W:0]   exp;
        int last_done = -1;
        int seen = 0;
        int cyc = 0;
        qa.push_back(W'($urandom));
        qb.push_back(W'($urandom));
        qc.push_back(1'($urandom));
        start = 1'b1;
        A = qa[0];
        B = qb[0];
        Cin = qc[0];
        while (seen < 4 && cyc < 8 * (W + 2)) begin
            tick();
            cyc++;
            if (done) begin
                exp = model_sum(qa[0], qb[0], qc[0]);
                n_cmp++;
                if ({Cout, S} !== exp) begin
                    n_bad++;
                    $display("FAIL b2b%0d sum: got %b_%h want %b_%h",
                             seen, Cout, S, exp[W], exp[W-1:0]);
                end
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc - last_done !== W + 2) begin
                        n_bad++;
                        $display("FAIL b2b%0d gap: got %0d want %0d",
                                 seen, cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                seen++;
                void'(qa.pop_front());
                void'(qb.pop_front());
                void'(qc.pop_front());
                qa.push_back(W'($urandom));
                qb.push_back(W'($urandom));
                qc.push_back(1'($urandom));
                A = qa[0];
                B = qb[0];
                Cin = qc[0];
            end
        end
        start = 1'b0;
        n_cmp++;
        if (seen !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 4", seen);
        end
        repeat (W + 3) tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
